// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave: AHB-Lite slave backed by an internal word-organised memory.
// Ports:
//   HCLK, HRESETn             - bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,      - address phase: select, byte address, transfer type,
//   HWRITE, HSIZE, HBURST       direction, size (HBURST is accepted but ignored)
//   HWDATA                    - write data, sampled in the completing data-phase cycle
//   HREADY                    - global ready; address phase sampled only when high
//   HREADYOUT, HRESP, HRDATA  - slave ready, OKAY/ERROR response, read data
//   wr_count                  - number of committed writes, wraps at 2^32
module ahb3lite_sram_slave #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [31:0]           wr_count
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'(NB);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  dp_valid;
    logic                  dp_write;
    logic [AW-1:0]         dp_word;
    logic [OB-1:0]         dp_lane;
    logic [2:0]            dp_size;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [32:0]           diff;
    logic [7:0]            amask;
    logic                  accept;
    logic                  err;
    logic                  commit;
    logic [NB-1:0]         be;
    logic                  unused;

    assign unused = ^{HBURST, HTRANS[0]};

    always_comb begin
        // 33-bit offset: a borrow (address below base) lands above MEM_BYTES too
        diff   = {1'b0, HADDR} - {1'b0, BASE_ADDR};
        amask  = (8'd1 << HSIZE) - 8'd1;
        accept = HSEL & HREADY & HTRANS[1];
        err    = (diff >= MEM_BYTES) || (HSIZE > 3'(OB)) || (|(HADDR[7:0] & amask));
        commit = state == ST_IDLE && dp_valid && dp_write;
        // 2^(2^size) - 1 wraps to all ones for a full-width access
        be     = ((NB'(1) << (NB'(1) << dp_size)) - NB'(1)) << dp_lane;
        HRDATA = (state == ST_IDLE && dp_valid && !dp_write) ? mem[dp_word] : '0;
    end

    always_ff @(posedge HCLK)
        if (commit)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[dp_word][8*i +: 8] <= HWDATA[8*i +: 8];

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_word   <= '0;
            dp_lane   <= '0;
            dp_size   <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            wr_count  <= '0;
        end else begin
            if (commit) wr_count <= wr_count + 32'd1;
            case (state)
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    // ST_IDLE / ST_ERR2: any pending data phase completes now, so a new one may start
                    dp_valid  <= accept && !err;
                    dp_write  <= HWRITE;
                    dp_word   <= diff[AW+OB-1:OB];
                    dp_lane   <= diff[OB-1:0];
                    dp_size   <= HSIZE;
                    state     <= !accept ? ST_IDLE : err ? ST_ERR1 : (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
                    cnt       <= (accept && !err) ? 4'(WAIT_STATES) : 4'd0;
                    HREADYOUT <= !accept || (!err && WAIT_STATES == 0);
                    HRESP     <= accept && err;
                end
            endcase
        end
endmodule

// File: doc/ahb3lite_sram_slave.md
# ahb3lite_sram_slave

Parametrised AHB-Lite slave with an internal word-organised memory, supporting reads and writes, byte/halfword/word sizes, programmable wait states and a two-cycle ERROR response. It succeeds the write-only DMA slave path: it attaches directly to the AHB-Lite bus and replaces the separate slave-plus-external-memory pairing with one self-contained target. It serves both as a DMA write sink and as a CPU-readable buffer.

## Interface
Parameters:
- DATA_WIDTH, 32, bus data width; one of 32 or 64.
- DEPTH, 1024, memory depth in DATA_WIDTH words; power of two.
- BASE_ADDR, 32'h0000_0000, byte base address; aligned to DEPTH*DATA_WIDTH/8.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer; range 0..15.

Ports:
- HCLK  in  1  bus clock; all logic rises on posedge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word, 3 = dword (64-bit only).
- HBURST  in  3  accepted; does not alter behaviour.
- HWDATA  in  DATA_WIDTH  write data, data phase.
- HREADY  in  1  global ready; address phase is sampled only when high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.
- wr_count  out  32  count of committed writes; wraps at 2^32.

## Operation
- Transfer accept: HSEL & HREADY & HTRANS[1] on a rising edge. Latch address, write, size and error flag into data-phase registers.
- Error flag: set when any of the following holds:
  - HADDR − BASE_ADDR ≥ DEPTH*DATA_WIDTH/8, or HADDR < BASE_ADDR;
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR is not aligned to 2^HSIZE.
- IDLE, BUSY, or unselected cycles start no data phase. The next cycle reports HREADYOUT=1, HRESP=0.
- State machine:
  - ST_IDLE: no pending data phase, or current data phase completes this cycle.
  - ST_WAIT: counter > 0, HREADYOUT=0.
  - ST_ERR1: HREADYOUT=0, HRESP=1.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Accepted OKAY with WAIT_STATES>0 → ST_WAIT, counter=WAIT_STATES. Decrement each cycle; at 0 → completion cycle (ST_IDLE semantics, HREADYOUT=1).
  - Accepted OKAY with WAIT_STATES=0 → completion immediately in the next cycle.
  - Accepted error → ST_ERR1 → ST_ERR2 → ST_IDLE. No wait states apply to errors.
- Write commit: on the edge ending the completing data-phase cycle. Byte lanes are little-endian; lane offset = address low bits. Only the addressed HSIZE bytes are updated. wr_count increments by 1 on each commit.
- Read: HRDATA = full memory word at the latched word address during the completing cycle; 0 in all other cycles. Byte selection is left to the master.
- Errored transfers never write memory and never increment wr_count.
- A new address phase may be accepted in the completing cycle (pipelined). No address phase is accepted while HREADYOUT=0, since HREADY is low.
- The data phase completes even if HSEL drops after acceptance.
- During ST_ERR2 the master may issue IDLE. A transfer accepted in ST_ERR2 is handled normally.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, wr_count=0, state ST_IDLE, counter 0. Memory contents are not reset (undefined).
- Reset asserted mid data phase: the transfer is abandoned, with no write and no count. Outputs go to reset values immediately (asynchronously).
- Latency:
  - OKAY transfer: data phase lasts WAIT_STATES+1 cycles.
  - Error: data phase lasts exactly 2 cycles.
- Back-to-back write then read of the same address with WAIT_STATES=0: the read returns the new data. The write commits before the read data phase.
- HRESP changes only on HCLK edges and is held high for both error cycles.

## Test plan
- Reset: HRESETn low for 3 cycles → HREADYOUT=1, HRESP=0, HRDATA=0, wr_count=0. Release mid-cycle → no spurious transfer.
- WAIT_STATES=0:
  - Word write 32'hDEADBEEF to BASE+0x10, then read BASE+0x10 back-to-back → HRDATA=32'hDEADBEEF in the cycle after the read address phase; wr_count=1.
- Byte lanes:
  - Write word 32'h11223344 to 0x20.
  - Write byte 8'hAA at 0x21 (HWDATA=32'h0000AA00).
  - Write half 16'hBBCC at 0x22 (HWDATA=32'hBBCC0000).
  - Read 0x20 → 32'hBBCCAA44.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, then high with data. An INCR4 SEQ write burst → each beat takes 4 cycles; wr_count=4 at the end.
- Error cases:
  - Access at BASE+DEPTH*4 → HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then OKAY. Memory unchanged and wr_count unchanged.
  - Repeat with HSIZE=2 at address 0x02 (misaligned) and with HSIZE=3 on a 32-bit build → same two-cycle ERROR.
- Reset during ST_WAIT of a write: assert HRESETn low → no memory update, wr_count=0, and HREADYOUT=1 immediately.
